// File: rtl/results_receiver.sv
// Loader side of the CPU-bus result/input transfer: assembles 32-bit beats into
// RAM words and writes header counts, T values and row-major X values to port A.
module results_receiver #(
  parameter int ADDRESS_WIDTH         = 13,
  parameter int DATA_WIDTH            = 64,
  parameter int NUMBER_OF_T_ADDRESS   = 1,
  parameter int NUMBER_OF_X_ADDRESS   = 2,
  parameter int STARTING_OF_T_ADDRESS = 3,
  parameter int STARTING_OF_X_ADDRESS = 10,
  parameter int COUNTER_SIZE          = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Receiving_Enable,
  input  logic                     CPU_Valid,
  input  logic [31:0]              CPU_Bus,
  output logic                     RAM_Write_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic                     Done_Receiving,
  output logic                     Error
);

  typedef enum logic [2:0] {IDLE, HDR_T, HDR_X, RECV_T, RECV_X, DONE, ERR} state_t;

  localparam logic [COUNTER_SIZE-1:0] ONE = COUNTER_SIZE'(1);

  state_t                   state_q, state_d;
  logic [COUNTER_SIZE-1:0]  num_of_T, num_of_X, t_idx, x_idx;
  logic                     active, accept, last_x, last_t;
  logic                     word_vld_p0;
  logic [DATA_WIDTH-1:0]    word_p0;
  logic [COUNTER_SIZE-1:0]  word_cnt;
  logic [ADDRESS_WIDTH-1:0] wr_addr;

  // A header is unusable if either count is zero, the T values would spill
  // into the X region, or the X block would run past the end of the RAM.
  function automatic logic header_illegal(input logic [COUNTER_SIZE-1:0] nt,
                                          input logic [COUNTER_SIZE-1:0] nx);
    logic [63:0] span;
    span = 64'(STARTING_OF_X_ADDRESS) + 64'(nt) * 64'(nx);
    return (nt == '0) || (nx == '0) ||
           (32'(nt) > 32'(STARTING_OF_X_ADDRESS - STARTING_OF_T_ADDRESS)) ||
           (span > (64'd1 << ADDRESS_WIDTH));
  endfunction

  // Stage p0: beat assembly into a complete word
  generate
    if (DATA_WIDTH == 64) begin : g_w64
      logic [31:0] half_q;
      logic        half_full;

      always_ff @(posedge CLK) begin
        if (RST) begin
          half_full <= 1'b0;
          half_q    <= '0;
        end else if (!(active && Receiving_Enable)) begin
          half_full <= 1'b0;
        end else if (accept) begin
          half_full <= ~half_full;
          if (!half_full) half_q <= CPU_Bus;
        end
      end

      assign word_vld_p0 = accept && half_full;
      assign word_p0     = {half_q, CPU_Bus};
    end else begin : g_w32
      assign word_vld_p0 = accept;
      assign word_p0     = CPU_Bus;
    end
  endgenerate

  assign word_cnt = word_p0[COUNTER_SIZE-1:0];
  assign last_x   = (x_idx == num_of_X - ONE);
  assign last_t   = (t_idx == num_of_T - ONE);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (Receiving_Enable) state_d = HDR_T;
      HDR_T:  if (!Receiving_Enable) state_d = IDLE;
              else if (word_vld_p0) state_d = HDR_X;
      HDR_X:  if (!Receiving_Enable) state_d = IDLE;
              else if (word_vld_p0)
                state_d = header_illegal(num_of_T, word_cnt) ? ERR : RECV_T;
      RECV_T: if (!Receiving_Enable) state_d = IDLE;
              else if (word_vld_p0) state_d = RECV_X;
      RECV_X: if (!Receiving_Enable) state_d = IDLE;
              else if (word_vld_p0 && last_x) state_d = last_t ? DONE : RECV_T;
      DONE, ERR: if (!Receiving_Enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == HDR_T) || (state_q == HDR_X) ||
             (state_q == RECV_T) || (state_q == RECV_X);
    accept = active && Receiving_Enable && CPU_Valid;
    Error  = (state_q == ERR);
  end

  always_comb begin
    wr_addr = '0;
    case (state_q)
      HDR_T:  wr_addr = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
      HDR_X:  wr_addr = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
      RECV_T: wr_addr = ADDRESS_WIDTH'(STARTING_OF_T_ADDRESS) + ADDRESS_WIDTH'(t_idx);
      RECV_X: wr_addr = ADDRESS_WIDTH'(STARTING_OF_X_ADDRESS) + ADDRESS_WIDTH'(x_idx) +
                        ADDRESS_WIDTH'(num_of_X) * ADDRESS_WIDTH'(t_idx);
      default: wr_addr = '0;
    endcase
  end

  // Stage p1: registered RAM write and index bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      RAM_Write_Enable <= 1'b0;
      RAM_Address      <= '0;
      RAM_Data         <= '0;
      Done_Receiving   <= 1'b0;
      num_of_T         <= '0;
      num_of_X         <= '0;
      t_idx            <= '0;
      x_idx            <= '0;
    end else begin
      RAM_Write_Enable <= word_vld_p0;
      // Done lags the final strobe by one cycle and drops as soon as enable falls.
      Done_Receiving   <= (state_q == DONE) && (state_d == DONE);
      if (word_vld_p0) begin
        RAM_Address <= wr_addr;
        RAM_Data    <= word_p0;
        case (state_q)
          HDR_T:  num_of_T <= word_cnt;
          HDR_X:  begin
            num_of_X <= word_cnt;
            t_idx    <= '0;
          end
          RECV_T: x_idx <= '0;
          RECV_X: begin
            if (!last_x) begin
              x_idx <= x_idx + ONE;
            end else if (!last_t) begin
              t_idx <= t_idx + ONE;
              x_idx <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_results_receiver.sv
// Bench for results_receiver: 64-bit and 32-bit instances driven with random
// payloads and compared against a layout model of the expected RAM writes.
module tb_results_receiver;

  logic        CLK, RST;
  logic        re64, v64, we64, done64, err64;
  logic [31:0] bus64;
  logic [12:0] a64;
  logic [63:0] d64;
  logic        re32, v32, we32, done32, err32;
  logic [31:0] bus32;
  logic [12:0] a32;
  logic [31:0] d32;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [12:0] ma64[$];
  logic [63:0] md64[$];
  int          mc64[$];
  logic [12:0] ma32[$];
  logic [31:0] md32[$];
  int          mc32[$];
  logic [12:0] ea[$];
  logic [63:0] ed[$];

  results_receiver u64 (
    .CLK(CLK), .RST(RST), .Receiving_Enable(re64), .CPU_Valid(v64), .CPU_Bus(bus64),
    .RAM_Write_Enable(we64), .RAM_Address(a64), .RAM_Data(d64),
    .Done_Receiving(done64), .Error(err64)
  );

  results_receiver #(.DATA_WIDTH(32)) u32 (
    .CLK(CLK), .RST(RST), .Receiving_Enable(re32), .CPU_Valid(v32), .CPU_Bus(bus32),
    .RAM_Write_Enable(we32), .RAM_Address(a32), .RAM_Data(d32),
    .Done_Receiving(done32), .Error(err32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (we64 === 1'b1) begin
      ma64.push_back(a64); md64.push_back(d64); mc64.push_back(cyc);
    end
    if (we32 === 1'b1) begin
      ma32.push_back(a32); md32.push_back(d32); mc32.push_back(cyc);
    end
  end

  task automatic clear_queues();
    ma64.delete(); md64.delete(); mc64.delete();
    ma32.delete(); md32.delete(); mc32.delete();
    ea.delete(); ed.delete();
  endtask

  task automatic beat64(input logic [31:0] b, input bit gaps);
    if (gaps) begin
      int n = $urandom_range(1, 3);
      repeat (n) begin
        @(negedge CLK); v64 = 1'b0; bus64 = $urandom;
      end
    end
    @(negedge CLK); v64 = 1'b1; bus64 = b;
  endtask

  // Layout model: header counts at 1 and 2, T[t] at 3+t, X[t][x] at 10+x+nx*t,
  // in stream order; only fully sent words are expected. limit=0 sends all beats.
  task automatic drive_stream64(input int nt, input int nx, input bit gaps, input int limit);
    logic [63:0] w[$];
    logic [12:0] a[$];
    int sent;
    w.push_back(64'(nt)); a.push_back(13'd1);
    w.push_back(64'(nx)); a.push_back(13'd2);
    for (int t = 0; t < nt; t++) begin
      w.push_back({$urandom, $urandom}); a.push_back(13'(3 + t));
      for (int x = 0; x < nx; x++) begin
        w.push_back({$urandom, $urandom}); a.push_back(13'(10 + x + nx * t));
      end
    end
    @(negedge CLK); re64 = 1'b1; v64 = 1'b0;
    sent = 0;
    foreach (w[i]) begin
      if (limit > 0 && sent >= limit) break;
      beat64(w[i][63:32], gaps); sent++;
      if (limit > 0 && sent >= limit) break;
      beat64(w[i][31:0], gaps); sent++;
      ea.push_back(a[i]); ed.push_back(w[i]);
    end
    if (limit == 0) begin
      @(negedge CLK); v64 = 1'b0; bus64 = '0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if (we64 !== 1'b0) begin failures++; $display("FAIL reset_we64 got=%b want=0", we64); end
    checks++; if (a64 !== '0) begin failures++; $display("FAIL reset_addr64 got=%0d want=0", a64); end
    checks++; if (d64 !== '0) begin failures++; $display("FAIL reset_data64 got=%h want=0", d64); end
    checks++; if (done64 !== 1'b0) begin failures++; $display("FAIL reset_done64 got=%b want=0", done64); end
    checks++; if (err64 !== 1'b0) begin failures++; $display("FAIL reset_err64 got=%b want=0", err64); end
    checks++; if ({we32, a32, d32, done32, err32} !== '0) begin
      failures++; $display("FAIL reset_dut32 got we=%b a=%0d d=%h done=%b err=%b want all 0",
                           we32, a32, d32, done32, err32);
    end
    RST = 1'b0;
  endtask

  task automatic test_stream(input string name, input int nt, input int nx, input bit gaps);
    int done_cyc;
    clear_queues();
    drive_stream64(nt, nx, gaps, 0);
    done_cyc = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (done64 === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end
    checks++;
    if (ma64.size() != ea.size()) begin
      failures++; $display("FAIL %s_write_count got=%0d want=%0d", name, ma64.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < ma64.size(); i++) begin
      checks++;
      if (ma64[i] !== ea[i] || md64[i] !== ed[i]) begin
        failures++;
        $display("FAIL %s_write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                 name, i, ma64[i], md64[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (mc64.size() == 0 || done_cyc != mc64[mc64.size()-1] + 1) begin
      failures++; $display("FAIL %s_done_timing got cycle=%0d want one after last strobe", name, done_cyc);
    end
    checks++; if (err64 !== 1'b0) begin failures++; $display("FAIL %s_error got=%b want=0", name, err64); end
    @(negedge CLK); re64 = 1'b0;
    @(negedge CLK);
    checks++; if (done64 !== 1'b0) begin failures++; $display("FAIL %s_done_clear got=%b want=0", name, done64); end
  endtask

  task automatic test_bad_header();
    int nts[3] = '{8, 0, 2};
    int nxs[3] = '{1, 3, 0};
    for (int h = 0; h < 3; h++) begin
      clear_queues();
      drive_stream64(nts[h], nxs[h], 1'b0, 4);
      @(negedge CLK);
      checks++; if (err64 !== 1'b1 || we64 !== 1'b1) begin
        failures++; $display("FAIL bad_hdr%0d_err_timing got err=%b we=%b want err=1 we=1", h, err64, we64);
      end
      v64 = 1'b1; bus64 = $urandom;
      repeat (6) begin @(negedge CLK); bus64 = $urandom; end
      @(negedge CLK); v64 = 1'b0;
      checks++;
      if (ma64.size() != 2 || ma64[0] !== 13'd1 || ma64[1] !== 13'd2 ||
          md64[0] !== ed[0] || md64[1] !== ed[1]) begin
        failures++; $display("FAIL bad_hdr%0d_writes got count=%0d want 2 writes to 1,2", h, ma64.size());
      end
      checks++; if (err64 !== 1'b1) begin failures++; $display("FAIL bad_hdr%0d_err_hold got=%b want=1", h, err64); end
      re64 = 1'b0;
      @(negedge CLK);
      checks++; if (err64 !== 1'b0) begin failures++; $display("FAIL bad_hdr%0d_err_clear got=%b want=0", h, err64); end
    end
  endtask

  task automatic test_abort();
    clear_queues();
    drive_stream64(2, 2, 1'b0, 5);
    @(negedge CLK); re64 = 1'b0; v64 = 1'b1; bus64 = $urandom;
    @(negedge CLK); v64 = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (ma64.size() != 2 || ma64[0] !== 13'd1 || ma64[1] !== 13'd2) begin
      failures++; $display("FAIL abort_writes got count=%0d want 2 writes to 1,2", ma64.size());
    end
    checks++; if (done64 !== 1'b0 || err64 !== 1'b0) begin
      failures++; $display("FAIL abort_idle got done=%b err=%b want 0 0", done64, err64);
    end
    test_stream("abort_restart", 1, 1, 1'b0);
  endtask

  task automatic test_w32();
    logic [31:0] w[5];
    logic [12:0] a[5] = '{13'd1, 13'd2, 13'd3, 13'd10, 13'd11};
    int bc[5];
    int seen_done;
    clear_queues();
    w[0] = 32'd1; w[1] = 32'd2;
    for (int i = 2; i < 5; i++) w[i] = $urandom;
    @(negedge CLK); re32 = 1'b1; v32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); v32 = 1'b1; bus32 = w[i]; bc[i] = cyc;
    end
    @(negedge CLK); v32 = 1'b0;
    seen_done = 0;
    repeat (4) begin @(negedge CLK); if (done32 === 1'b1) seen_done = 1; end
    checks++; if (ma32.size() != 5) begin failures++; $display("FAIL w32_count got=%0d want=5", ma32.size()); end
    for (int i = 0; i < 5 && i < ma32.size(); i++) begin
      checks++;
      if (ma32[i] !== a[i] || md32[i] !== w[i] || mc32[i] != bc[i] + 1) begin
        failures++;
        $display("FAIL w32_write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 i, ma32[i], md32[i], mc32[i], a[i], w[i], bc[i] + 1);
      end
    end
    checks++; if (seen_done != 1) begin failures++; $display("FAIL w32_done got=%0d want=1", seen_done); end
    re32 = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int n_before;
    clear_queues();
    drive_stream64(2, 3, 1'b0, 9);
    @(negedge CLK); RST = 1'b1; v64 = 1'b1; bus64 = $urandom;
    @(negedge CLK);
    checks++; if ({we64, a64, d64, done64, err64} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got we=%b a=%0d d=%h done=%b err=%b want all 0",
                           we64, a64, d64, done64, err64);
    end
    RST = 1'b0; re64 = 1'b0;
    n_before = ma64.size();
    repeat (4) begin @(negedge CLK); v64 = 1'b1; bus64 = $urandom; end
    @(negedge CLK); v64 = 1'b0;
    @(negedge CLK);
    checks++; if (n_before != 4 || ma64.size() != n_before) begin
      failures++; $display("FAIL rst_mid_ignored got before=%0d after=%0d want 4 4", n_before, ma64.size());
    end
    test_stream("rst_recover", 1, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++)
      test_stream("random", $urandom_range(1, 7), $urandom_range(1, 4), 1'b1);
  endtask

  initial begin
    RST = 1'b1;
    re64 = 1'b0; v64 = 1'b0; bus64 = '0;
    re32 = 1'b0; v32 = 1'b0; bus32 = '0;
    test_reset();
    test_stream("nominal", 2, 3, 1'b0);
    test_stream("gapped", 2, 3, 1'b1);
    test_bad_header();
    test_abort();
    test_w32();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
